// File: rtl/taxi_eth_link_recovery_pkg.sv
// Shared types for the link-recovery block: sequencer states, watchdog states
// and a counter-width helper.
package taxi_eth_link_recovery_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOST_SETUP,
        HOST_ACCESS,
        ASSERT_WR,
        PULSE_WAIT,
        RELEASE_WR
    } seq_state_t;

    typedef enum logic {
        WD_ARMED,
        WD_HOLD
    } wd_state_t;

    // Width of a counter that must reach the larger of two terminal values.
    function automatic int ctr_w(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/taxi_eth_link_watchdog.sv
// Single-lane link watchdog: rx_status synchronizer, link-down timer and the
// post-recovery holdoff that keeps a freshly reset lane from retriggering.
module taxi_eth_link_watchdog
    import taxi_eth_link_recovery_pkg::*;
#(
    parameter int LINK_TIMEOUT = 1250000,
    parameter int HOLDOFF      = 12500000
)(
    input  logic clk,
    input  logic rst_n,
    input  logic rx_status,
    input  logic cfg_enable,
    input  logic pend_clr,
    input  logic recov_done,
    output logic link_up,
    output logic pend
);

    localparam int CW = ctr_w(LINK_TIMEOUT, HOLDOFF);

    logic [1:0]    sync_q;
    wd_state_t     state;
    logic [CW-1:0] cnt;

    assign link_up = sync_q[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            state  <= WD_ARMED;
            cnt    <= '0;
            pend   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rx_status};
            if (pend_clr || !cfg_enable)
                pend <= 1'b0;
            case (state)
                WD_ARMED: begin
                    if (recov_done) begin
                        state <= WD_HOLD;
                        cnt   <= '0;
                        pend  <= 1'b0;
                    end else if (!cfg_enable || link_up) begin
                        cnt <= '0;
                    end else if (cnt == CW'(LINK_TIMEOUT - 2)) begin
                        // pend fires once on reaching the terminal count; the
                        // saturated counter keeps it from re-requesting
                        cnt  <= cnt + 1'b1;
                        pend <= 1'b1;
                    end else if (cnt != CW'(LINK_TIMEOUT - 1)) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WD_HOLD: begin
                    if (cnt == CW'(HOLDOFF - 1)) begin
                        state <= WD_ARMED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/taxi_eth_link_recovery.sv
// Per-lane link watchdogs plus a sequencer that shares the GT APB control port
// between the host bridge and the automatic reset-pulse recovery writes.
module taxi_eth_link_recovery
    import taxi_eth_link_recovery_pkg::*;
#(
    parameter int                CNT             = 4,
    parameter int                ADDR_W          = 18,
    parameter int                DATA_W          = 16,
    parameter int                LINK_TIMEOUT    = 1250000,
    parameter int                HOLDOFF         = 12500000,
    parameter logic [ADDR_W-1:0] RST_ADDR_BASE   = '0,
    parameter logic [ADDR_W-1:0] RST_ADDR_STEP   = ADDR_W'(32'h1000),
    parameter logic [DATA_W-1:0] RST_ASSERT_VAL  = DATA_W'(1),
    parameter logic [DATA_W-1:0] RST_RELEASE_VAL = '0,
    parameter int                RST_PULSE       = 64,
    localparam int               STRB_W          = DATA_W / 8,
    localparam int               CH_W            = (CNT > 1) ? $clog2(CNT) : 1
)(
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] s_apb_paddr,
    input  logic [2:0]        s_apb_pprot,
    input  logic              s_apb_psel,
    input  logic              s_apb_penable,
    input  logic              s_apb_pwrite,
    input  logic [DATA_W-1:0] s_apb_pwdata,
    input  logic [STRB_W-1:0] s_apb_pstrb,
    output logic              s_apb_pready,
    output logic [DATA_W-1:0] s_apb_prdata,
    output logic              s_apb_pslverr,

    output logic [ADDR_W-1:0] m_apb_paddr,
    output logic [2:0]        m_apb_pprot,
    output logic              m_apb_psel,
    output logic              m_apb_penable,
    output logic              m_apb_pwrite,
    output logic [DATA_W-1:0] m_apb_pwdata,
    output logic [STRB_W-1:0] m_apb_pstrb,
    input  logic              m_apb_pready,
    input  logic [DATA_W-1:0] m_apb_prdata,
    input  logic              m_apb_pslverr,

    input  logic [CNT-1:0]    rx_status,
    input  logic [CNT-1:0]    cfg_enable,
    output logic [CNT-1:0]    link_up,
    output logic              recov_active,
    output logic [CH_W-1:0]   recov_ch,
    output logic              recov_done,
    output logic              recov_err
);

    localparam int PW = $clog2(RST_PULSE + 1);

    seq_state_t        state, state_nx;
    logic [CH_W-1:0]   ch_q, ch_nx, last_ch, rr_ch, rr_idx;
    logic              rr_found;
    logic              wr_phase, wr_phase_nx;
    logic              host_prio, host_prio_nx;
    logic [PW-1:0]     pulse_cnt, pulse_cnt_nx;
    logic [CNT-1:0]    pend, pend_clr, done_vec;
    logic              wr_done, done_evt, err_evt;
    logic [ADDR_W-1:0] rst_addr;

    for (genvar g = 0; g < CNT; g++) begin : g_lane
        assign done_vec[g] = done_evt && (ch_q == CH_W'(g));

        taxi_eth_link_watchdog #(
            .LINK_TIMEOUT (LINK_TIMEOUT),
            .HOLDOFF      (HOLDOFF)
        ) u_wd (
            .clk          (clk),
            .rst_n        (rst_n),
            .rx_status    (rx_status[g]),
            .cfg_enable   (cfg_enable[g]),
            .pend_clr     (pend_clr[g]),
            .recov_done   (done_vec[g]),
            .link_up      (link_up[g]),
            .pend         (pend[g])
        );
    end

    // Round-robin: first pending lane strictly after the last one recovered.
    always_comb begin
        rr_ch    = '0;
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int i = 1; i <= CNT; i++) begin
            rr_idx = CH_W'((int'(last_ch) + i) % CNT);
            if (!rr_found && pend[rr_idx]) begin
                rr_found = 1'b1;
                rr_ch    = rr_idx;
            end
        end
    end

    assign rst_addr     = RST_ADDR_BASE + ADDR_W'(ch_q) * RST_ADDR_STEP;
    assign wr_done      = wr_phase && m_apb_pready;
    assign recov_active = (state == ASSERT_WR) || (state == PULSE_WAIT) || (state == RELEASE_WR);
    assign recov_ch     = recov_active ? ch_q : '0;

    always_comb begin
        state_nx      = state;
        ch_nx         = ch_q;
        wr_phase_nx   = 1'b0;
        host_prio_nx  = host_prio;
        pulse_cnt_nx  = pulse_cnt;
        pend_clr      = '0;
        done_evt      = 1'b0;
        err_evt       = 1'b0;
        m_apb_psel    = 1'b0;
        m_apb_penable = 1'b0;
        m_apb_pwrite  = 1'b0;
        m_apb_paddr   = '0;
        m_apb_pwdata  = '0;
        m_apb_pstrb   = '0;
        m_apb_pprot   = '0;
        s_apb_pready  = 1'b0;
        s_apb_prdata  = '0;
        s_apb_pslverr = 1'b0;

        case (state)
            IDLE: begin
                if (s_apb_psel && (host_prio || !rr_found)) begin
                    state_nx = HOST_SETUP;
                end else if (rr_found) begin
                    state_nx         = ASSERT_WR;
                    ch_nx            = rr_ch;
                    pend_clr[rr_ch]  = 1'b1;
                end
            end
            HOST_SETUP, HOST_ACCESS: begin
                m_apb_psel    = 1'b1;
                m_apb_penable = (state == HOST_ACCESS);
                m_apb_pwrite  = s_apb_pwrite;
                m_apb_paddr   = s_apb_paddr;
                m_apb_pwdata  = s_apb_pwdata;
                m_apb_pstrb   = s_apb_pstrb;
                m_apb_pprot   = s_apb_pprot;
                if (state == HOST_SETUP) begin
                    state_nx = HOST_ACCESS;
                end else begin
                    s_apb_pready  = m_apb_pready && s_apb_penable;
                    s_apb_prdata  = m_apb_prdata;
                    s_apb_pslverr = m_apb_pslverr;
                    if (m_apb_pready) begin
                        state_nx     = IDLE;
                        host_prio_nx = 1'b0;
                    end
                end
            end
            ASSERT_WR, RELEASE_WR: begin
                m_apb_psel    = 1'b1;
                m_apb_penable = wr_phase;
                m_apb_pwrite  = 1'b1;
                m_apb_paddr   = rst_addr;
                m_apb_pwdata  = (state == ASSERT_WR) ? RST_ASSERT_VAL : RST_RELEASE_VAL;
                m_apb_pstrb   = '1;
                wr_phase_nx   = 1'b1;
                if (wr_done) begin
                    // an error is reported but never aborts: release must follow
                    wr_phase_nx = 1'b0;
                    err_evt     = m_apb_pslverr;
                    if (state == ASSERT_WR) begin
                        state_nx     = PULSE_WAIT;
                        pulse_cnt_nx = '0;
                    end else begin
                        state_nx     = IDLE;
                        done_evt     = 1'b1;
                        host_prio_nx = 1'b1;
                    end
                end
            end
            PULSE_WAIT: begin
                if (pulse_cnt == PW'(RST_PULSE - 1))
                    state_nx = RELEASE_WR;
                else
                    pulse_cnt_nx = pulse_cnt + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ch_q       <= '0;
            last_ch    <= CH_W'(CNT - 1);
            wr_phase   <= 1'b0;
            host_prio  <= 1'b0;
            pulse_cnt  <= '0;
            recov_done <= 1'b0;
            recov_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            ch_q       <= ch_nx;
            wr_phase   <= wr_phase_nx;
            host_prio  <= host_prio_nx;
            pulse_cnt  <= pulse_cnt_nx;
            recov_done <= done_evt;
            recov_err  <= err_evt;
            if (done_evt)
                last_ch <= ch_q;
        end
    end

endmodule
